mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle RV64M execution unit in the EX stage, alongside the ALU. It consumes the M-extension `alu_control` codes produced by the ALU decoder (`5'b01111`–`5'b11011`) and iterates one bit per cycle, using shift-add for multiply and restoring division for divide. While it computes, it holds `busy_o` so the hazard unit stalls the pipeline. It then presents a 64-bit result for exactly one `done_o` cycle.

## Interface
- No parameters. XLEN is fixed at 64; W-ops use 32-bit operands.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: EX holds an M-extension instruction. Sampled only in IDLE.
- `alu_control_i` input 5: operation code, with these assignments:
  - `01111` MUL, `10000` MULH, `10001` MULHSU, `10010` MULHU
  - `10011` DIV, `10100` DIVU, `10101` REM, `10110` REMU
  - `10111` MULW, `11000` DIVW, `11001` DIVUW, `11010` REMW, `11011` REMUW
- `src_a_i` input 64: rs1 operand (dividend or multiplicand).
- `src_b_i` input 64: rs2 operand (divisor or multiplier).
- `flush_i` input 1: pipeline flush. Aborts any operation in progress.
- `busy_o` output 1: stall request to the hazard unit.
- `done_o` output 1: `result_o` is valid this cycle.
- `result_o` output 64: the result. Holds its value until the next `done_o`.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE → CALC:** taken when `start_i` is high, the code is valid and the operation is not a special case. On entry:
  - capture operand magnitudes and signs, and the operation;
  - load counter = 64 (or 32 for W-ops).
- **IDLE → DONE:** taken directly when `start_i` is high with a division special case.
- **IDLE, invalid code:** if `start_i` is high with a code outside `01111`–`11011`, ignore it and stay in IDLE.
- **CALC:** one iteration per cycle, decrementing the counter. At counter = 1, the final iteration writes `result_o` and the FSM moves to DONE.
- **DONE:** `done_o` = 1 for exactly one cycle, then the FSM returns to IDLE.
- **Ignored starts:** `start_i` is ignored in CALC and in DONE.
- **Signedness:**
  - MUL, MULH, DIV, REM and signed W-ops: both operands signed.
  - MULHSU: `src_a_i` signed, `src_b_i` unsigned.
  - `*U` ops: both operands unsigned.
- **Operand preparation:** iterate on absolute values. W-ops first sign-extend (signed ops) or zero-extend (unsigned ops) `src_*_i[31:0]`.
- **Multiply:**
  - 128-bit accumulator; the product is negated at the end if the operand signs differ.
  - MUL returns product[63:0]. MULH, MULHSU and MULHU return product[127:64].
  - MULW returns product[31:0], sign-extended to 64 bits.
- **Divide:**
  - Restoring algorithm. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - W-ops compute on 32 bits and sign-extend bit 31 of the result. This applies to DIVUW and REMUW as well.
- **Special cases (no iteration, straight to DONE):**
  - Divide by zero: quotient = all ones at operation width; remainder = the dividend at operation width.
  - Signed overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
  - In both cases, W results are sign-extended.
- **Flush:** `flush_i` in CALC or DONE forces IDLE on the next edge. `done_o` stays 0 and `result_o` is not updated. In IDLE, `flush_i` suppresses a simultaneous `start_i`.

## Timing
- **Reset values:** state IDLE, `busy_o` 0, `done_o` 0, `result_o` 0, counter 0.
- **Reset priority:** reset mid-operation returns the unit to IDLE on that edge. Reset has priority over `flush_i`, and `flush_i` has priority over `start_i`.
- **`busy_o` (combinational):**
  - high when in IDLE with a valid `start_i` and no `flush_i`;
  - high when in CALC;
  - low in DONE, so the pipeline advances in the `done_o` cycle and captures `result_o` there.
- **Latency:** with `start_i` sampled at edge 0:
  - 64-bit ops: `done_o` high in cycle 65 (64 CALC cycles, then DONE).
  - W-ops: `done_o` high in cycle 33.
  - Special cases: `done_o` high in cycle 1.
- **Back-to-back:** the next `start_i` is accepted in the cycle after DONE, giving a minimum issue interval of N+2 cycles.
- **Operand stability:** operands are registered at start, so `src_*_i` may change from cycle 1 onward.

## Test plan
- **MUL:** `start_i` with MUL, a = 7, b = −3 → `busy_o` high for cycles 0–64, `done_o` in cycle 65, `result_o` = `0xFFFF_FFFF_FFFF_FFEB`.
- **MULHU / MULHSU:** a = b = all ones.
  - MULHU → `0xFFFF_FFFF_FFFF_FFFE`.
  - MULHSU → `0xFFFF_FFFF_FFFF_FFFF`.
- **Divide by zero and overflow, each checked for `done_o` in cycle 1:**
  - DIVU 5 / 0 → all ones.
  - REM 5 / 0 → 5.
  - DIV `0x8000_0000_0000_0000` / −1 → `0x8000_0000_0000_0000`.
  - REM of the same operands → 0.
- **W-ops:** `src_a_i` = `0x1234_5678_FFFF_FFF9` (low word = −7), b = 2.
  - DIVW → `0xFFFF_FFFF_FFFF_FFFD` (−3), with `done_o` in cycle 33.
  - REMW → −1.
  - DIVUW `0xFFFF_FFFF` / 1 → `0xFFFF_FFFF_FFFF_FFFF`.
- **Flush:** assert `flush_i` in cycle 10 of a DIV → IDLE next cycle, no `done_o`, `result_o` unchanged. A new MUL started one cycle later completes correctly.
- **Reset and ignored inputs:**
  - `rst_i` in cycle 20 of a DIVU → all outputs 0.
  - `start_i` held high during CALC causes no restart.
  - An invalid code (`00000`) with `start_i` leaves `busy_o` = 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Multiply: shift-add, one multiplier bit per cycle, on operand magnitudes.
// Divide: restoring, one quotient bit per cycle, on operand magnitudes.
// Signs are reapplied on the final iteration. Divide-by-zero and signed
// overflow skip iteration entirely.
module mul_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  alu_control_i,
    input  logic [63:0] src_a_i,
    input  logic [63:0] src_b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [63:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic [127:0]   acc_q, acc_d;
    logic           neg_q, neg_d, rneg_q, rneg_d;
    logic           mul_q, mul_d, w_q, w_d, hi_q, hi_d, rem_q, rem_d;

    // Operation decode from the ALU control code
    logic op_vld, op_mul, op_w, op_hi, op_rem, sgn_a, sgn_b;
    always_comb begin
        op_vld = 1'b1; op_mul = 1'b0; op_w = 1'b0; op_hi = 1'b0;
        op_rem = 1'b0; sgn_a = 1'b0; sgn_b = 1'b0;
        case (alu_control_i)
            5'b01111: begin op_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b10000: begin op_mul = 1'b1; op_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b10001: begin op_mul = 1'b1; op_hi = 1'b1; sgn_a = 1'b1; end
            5'b10010: begin op_mul = 1'b1; op_hi = 1'b1; end
            5'b10011: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b10100: ;
            5'b10101: begin op_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b10110: op_rem = 1'b1;
            5'b10111: begin op_mul = 1'b1; op_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b11000: begin op_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b11001: op_w = 1'b1;
            5'b11010: begin op_w = 1'b1; op_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            5'b11011: begin op_w = 1'b1; op_rem = 1'b1; end
            default:  op_vld = 1'b0;
        endcase
    end

    // Operand extension, magnitudes and special-case detection
    logic [63:0] ext_a, ext_b, mag_a, mag_b, min_neg, div0_res, ovf_res;
    logic        neg_a, neg_b, div0, ovf;
    always_comb begin
        ext_a    = op_w ? {{32{sgn_a & src_a_i[31]}}, src_a_i[31:0]} : src_a_i;
        ext_b    = op_w ? {{32{sgn_b & src_b_i[31]}}, src_b_i[31:0]} : src_b_i;
        neg_a    = sgn_a & ext_a[63];
        neg_b    = sgn_b & ext_b[63];
        mag_a    = neg_a ? -ext_a : ext_a;
        mag_b    = neg_b ? -ext_b : ext_b;
        min_neg  = op_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div0     = !op_mul && (ext_b == '0);
        ovf      = !op_mul && sgn_a && (ext_a == min_neg) && (ext_b == '1);
        // W remainders are always sign-extended, even for REMUW
        div0_res = op_rem ? (op_w ? {{32{src_a_i[31]}}, src_a_i[31:0]} : src_a_i) : '1;
        ovf_res  = op_rem ? '0 : ext_a;
    end

    // One multiply / divide step plus final sign fix-up and result select
    logic [64:0]  mul_sum, div_r;
    logic [127:0] acc_mul, prod, sprod;
    logic [63:0]  rem_n, a_div, quo, q_s, r_s, mul_res, div_res, fin_res;
    logic         div_ge;
    always_comb begin
        mul_sum = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, a_q} : 65'd0);
        acc_mul = {mul_sum, acc_q[63:1]};
        // W multiplies stop after 32 steps, leaving the product 32 bits high
        prod    = w_q ? (acc_mul >> 32) : acc_mul;
        sprod   = neg_q ? -prod : prod;
        mul_res = w_q ? {{32{sprod[31]}}, sprod[31:0]} : (hi_q ? sprod[127:64] : sprod[63:0]);

        div_r   = {acc_q[63:0], a_q[63]};
        div_ge  = div_r >= {1'b0, b_q};
        rem_n   = div_ge ? (div_r[63:0] - b_q) : div_r[63:0];
        a_div   = {a_q[62:0], div_ge};
        quo     = w_q ? {32'd0, a_div[31:0]} : a_div;
        q_s     = neg_q ? -quo : quo;
        r_s     = rneg_q ? -rem_n : rem_n;
        div_res = rem_q ? r_s : q_s;
        if (w_q) div_res = {{32{div_res[31]}}, div_res[31:0]};

        fin_res = mul_q ? mul_res : div_res;
    end

    // FSM next state, datapath loads and handshake outputs
    always_comb begin
        state_d = state_q; cnt_d = cnt_q; a_d = a_q; b_d = b_q; acc_d = acc_q;
        result_d = result_q; neg_d = neg_q; rneg_d = rneg_q;
        mul_d = mul_q; w_d = w_q; hi_d = hi_q; rem_d = rem_q;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && op_vld && !flush_i) begin
                    busy_o = 1'b1;
                    mul_d  = op_mul; w_d = op_w; hi_d = op_hi; rem_d = op_rem;
                    neg_d  = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    if (div0 || ovf) begin
                        result_d = div0 ? div0_res : ovf_res;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                        cnt_d   = op_w ? 7'd32 : 7'd64;
                        b_d     = mag_b;
                        if (op_mul) begin
                            a_d   = mag_a;
                            acc_d = {64'd0, mag_b};
                        end else begin
                            // W dividend sits in the top half so bits shift out first
                            a_d   = op_w ? {mag_a[31:0], 32'd0} : mag_a;
                            acc_d = '0;
                        end
                    end
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                    if (mul_q) begin
                        acc_d = acc_mul;
                    end else begin
                        a_d   = a_div;
                        acc_d = {64'd0, rem_n};
                    end
                    if (cnt_q == 7'd1) begin
                        result_d = fin_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                done_o  = !flush_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE; cnt_q <= '0; a_q <= '0; b_q <= '0; acc_q <= '0;
            result_q <= '0; neg_q <= 1'b0; rneg_q <= 1'b0;
            mul_q <= 1'b0; w_q <= 1'b0; hi_q <= 1'b0; rem_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; a_q <= a_d; b_q <= b_d; acc_q <= acc_d;
            result_q <= result_d; neg_q <= neg_d; rneg_q <= rneg_d;
            mul_q <= mul_d; w_q <= w_d; hi_q <= hi_d; rem_q <= rem_d;
        end
    end

    assign result_o = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, busy window, results, flush, reset.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [4:0]  op;
    logic [63:0] a, b;
    logic        busy, done;
    logic [63:0] res;
    logic [63:0] last;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [4:0] MUL = 5'b01111, MULH = 5'b10000, MULHSU = 5'b10001, MULHU = 5'b10010;
    localparam logic [4:0] DIV = 5'b10011, DIVU = 5'b10100, REM = 5'b10101, REMU = 5'b10110;
    localparam logic [4:0] MULW = 5'b10111, DIVW = 5'b11000, DIVUW = 5'b11001;
    localparam logic [4:0] REMW = 5'b11010, REMUW = 5'b11011;

    mul_div_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .alu_control_i(op),
        .src_a_i(a), .src_b_i(b), .flush_i(flush),
        .busy_o(busy), .done_o(done), .result_o(res)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one op in cycle 0 (called just after a rising edge) and measure
    // done latency, number of busy cycles and the result.
    task automatic run_op(input string tag, input logic [4:0] c, input logic [63:0] sa,
                          input logic [63:0] sb, input logic [63:0] exp, input int lat,
                          input bit hold);
        int          busy_n;
        int          got_lat;
        logic [63:0] got;
        busy_n = 0; got_lat = 0; got = '0;
        start = 1'b1; op = c; a = sa; b = sb;
        @(negedge clk);
        if (busy) busy_n++;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                got_lat = cyc;
                got = res;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " latency"}, 64'(got_lat), 64'(lat));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
        check({tag, " result"}, got, exp);
        last = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; last = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", res, 64'd0);
        @(posedge clk); #1;

        // invalid code is ignored
        start = 1'b1; op = 5'b00000; a = 64'd5; b = 64'd3;
        @(negedge clk);
        check("invalid busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("invalid idle busy", 64'(busy), 64'd0);
        check("invalid idle done", 64'(done), 64'd0);
        @(posedge clk); #1;

        // start held high through CALC must not restart the op
        run_op("MUL 7*-3", MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
        run_op("MULHU", MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("MULHSU", MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("MULH -2*3", MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("MULW", MULW, 64'hAAAA_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0);
        run_op("DIVU 5/0", DIVU, 64'd5, 64'd0, '1, 1, 1'b0);
        run_op("REM 5/0", REM, 64'd5, 64'd0, 64'd5, 1, 1'b0);
        run_op("DIV ovf", DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1'b0);
        run_op("REM ovf", REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b0);
        run_op("DIVW ovf", DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, 1'b0);
        run_op("REMUW /0", REMUW, 64'h1111_2222_8000_0001, 64'h5555_0000_0000_0000,
               64'hFFFF_FFFF_8000_0001, 1, 1'b0);
        run_op("DIV -100/7", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1'b0);
        run_op("REM -100/7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("REMU 100/7", REMU, 64'd100, 64'd7, 64'd2, 65, 1'b0);
        run_op("DIVW", DIVW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        run_op("REMW", REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
        run_op("DIVUW", DIVUW, 64'hABCD_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);

        // flush in cycle 10 of a DIV
        start = 1'b1; op = DIV; a = 64'd100; b = 64'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush result held", res, last);
        @(posedge clk); #1;
        run_op("MUL after flush", MUL, 64'd12345, 64'd678, 64'h7F_B6F6, 65, 1'b0);

        // reset in cycle 20 of a DIVU
        start = 1'b1; op = DIVU; a = 64'd1000; b = 64'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop reset busy", 64'(busy), 64'd0);
        check("midop reset done", 64'(done), 64'd0);
        check("midop reset result", res, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
